// File: rtl/result_display_pkg.sv
// Shared segment constants, conversion state type and nibble decode for result_display.
package result_display_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    // Active-low {g,f,e,d,c,b,a} patterns for decimal digits 0..9.
    localparam logic [6:0] SEG_DIGIT [10] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

    typedef enum logic [0:0] {
        IDLE,
        CONV
    } conv_state_e;

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] s;
        s = SEG_BLANK;
        if (nib <= 4'd9) s = SEG_DIGIT[nib];
        return s;
    endfunction

endpackage

// File: rtl/bin2bcd_iter.sv
// Iterative 16-bit binary to 5-digit BCD converter (shift-and-add-3, one bit per cycle).
module bin2bcd_iter
    import result_display_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] bin,
    output logic        busy,
    output logic        done,
    output logic [19:0] bcd
);

    conv_state_e state_q, state_d;
    logic [15:0] shreg_q, shreg_d;
    logic [19:0] acc_q, acc_d, adj;
    logic [3:0]  cnt_q, cnt_d;
    logic        done_q, done_d;

    always_comb begin
        adj = acc_q;
        for (int i = 0; i < 5; i++) begin
            if (acc_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
        end

        state_d = state_q;
        shreg_d = shreg_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    shreg_d = bin;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = CONV;
                end
            end
            CONV: begin
                {acc_d, shreg_d} = {adj, shreg_q} << 1;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q == CONV);
    assign done = done_q;
    assign bcd  = acc_q;

endmodule

// File: rtl/result_display.sv
// Converts a 16-bit result to BCD and drives a multiplexed 4-digit 7-segment display.
module result_display
    import result_display_pkg::*;
#(
    parameter int unsigned DIGIT_PERIOD = 1000,
    parameter bit          BLANK_ZEROS  = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] value,
    input  logic        load,
    output logic        busy,
    output logic        done,
    output logic [15:0] bcd_out,
    output logic        ovf,
    output logic [3:0]  an,
    output logic [6:0]  seg
);

    localparam int unsigned TickW = $clog2(DIGIT_PERIOD);

    logic             load_q, accept;
    logic [15:0]      value_q;
    logic [19:0]      conv_bcd;
    logic [15:0]      bcd_q;
    logic             ovf_q;
    logic [TickW-1:0] tick_q, tick_d;
    logic [1:0]       idx_q, idx_d;
    logic [3:0]       an_q;
    logic [6:0]       seg_q, seg_d;
    logic [3:0]       nib;
    logic             upper_zero;

    // A second load before the FSM has picked up the first one is dropped, like one while busy.
    assign accept = load & ~busy & ~load_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            load_q  <= 1'b0;
            value_q <= '0;
        end else begin
            load_q <= accept;
            if (accept) value_q <= value;
        end
    end

    bin2bcd_iter u_conv (
        .clk   (clk),
        .rst   (rst),
        .start (load_q),
        .bin   (value_q),
        .busy  (busy),
        .done  (done),
        .bcd   (conv_bcd)
    );

    // The finished result appears in the same cycle as done and is held afterwards.
    assign bcd_out = done ? conv_bcd[15:0] : bcd_q;
    assign ovf     = done ? (conv_bcd[19:16] != 4'd0) : ovf_q;

    always_comb begin
        tick_d = tick_q + TickW'(1);
        idx_d  = idx_q;
        if (tick_q == TickW'(DIGIT_PERIOD - 1)) begin
            tick_d = '0;
            idx_d  = idx_q + 2'd1;
        end
    end

    // Segments are computed for the next index so an and seg update on the same edge.
    always_comb begin
        nib        = bcd_out[{idx_d, 2'b00} +: 4];
        upper_zero = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i >= int'(idx_d) && bcd_out[4*i +: 4] != 4'd0) upper_zero = 1'b0;
        end
        if (ovf) begin
            seg_d = SEG_DASH;
        end else if (BLANK_ZEROS && idx_d != 2'd0 && upper_zero) begin
            seg_d = SEG_BLANK;
        end else begin
            seg_d = seg_decode(nib);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bcd_q  <= '0;
            ovf_q  <= 1'b0;
            tick_q <= '0;
            idx_q  <= '0;
            an_q   <= 4'b1110;
            seg_q  <= SEG_DIGIT[0];
        end else begin
            bcd_q  <= bcd_out;
            ovf_q  <= ovf;
            tick_q <= tick_d;
            idx_q  <= idx_d;
            an_q   <= ~(4'b0001 << idx_d);
            seg_q  <= seg_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;

endmodule

// File: tb/tb_result_display.sv
// Randomized self-checking bench for result_display against an arithmetic reference model.
module tb_result_display;

    localparam int unsigned P = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] value;
    logic        load;

    logic        busy, done, ovf;
    logic [15:0] bcd_out;
    logic [3:0]  an;
    logic [6:0]  seg;

    logic        busy_nb, done_nb, ovf_nb;
    logic [15:0] bcd_nb;
    logic [3:0]  an_nb;
    logic [6:0]  seg_nb;

    int checks   = 0;
    int failures = 0;
    int disp_v   = 0;

    always #5 clk = ~clk;

    result_display #(.DIGIT_PERIOD(P), .BLANK_ZEROS(1'b1)) dut (
        .clk(clk), .rst(rst), .value(value), .load(load), .busy(busy), .done(done),
        .bcd_out(bcd_out), .ovf(ovf), .an(an), .seg(seg)
    );

    result_display #(.DIGIT_PERIOD(P), .BLANK_ZEROS(1'b0)) dut_nb (
        .clk(clk), .rst(rst), .value(value), .load(load), .busy(busy_nb), .done(done_nb),
        .bcd_out(bcd_nb), .ovf(ovf_nb), .an(an_nb), .seg(seg_nb)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int pow10(input int n);
        int r;
        r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [15:0] model_bcd(input int v);
        logic [15:0] b;
        b = '0;
        for (int i = 0; i < 4; i++) b[4*i +: 4] = 4'((v / pow10(i)) % 10);
        return b;
    endfunction

    function automatic logic [6:0] digit_pattern(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // Leading zeros above digit d exist exactly when the value is below 10^d.
    function automatic logic [6:0] model_seg(input int v, input int d, input bit blank);
        if (v > 9999) return 7'b0111111;
        if (blank && d > 0 && v < pow10(d)) return 7'b1111111;
        return digit_pattern((v / pow10(d)) % 10);
    endfunction

    task automatic wait_done(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (done) seen = 1'b1;
            else @(negedge clk);
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic convert(input int v, input string tag);
        int busy_cnt;
        bit seen, stale;
        @(negedge clk);
        value = 16'(v);
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
        value = 16'($urandom);
        busy_cnt = 0;
        seen     = 1'b0;
        stale    = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (done) begin
                seen = 1'b1;
            end else begin
                if (busy) busy_cnt++;
                if (bcd_out !== model_bcd(disp_v)) stale = 1'b1;
                @(negedge clk);
            end
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd16);
        check({tag, "_bcd_held"}, 32'(stale), 32'd0);
        check({tag, "_bcd"}, 32'(bcd_out), 32'(model_bcd(v)));
        check({tag, "_ovf"}, 32'(ovf), 32'(v > 9999));
        check({tag, "_bcd_nb"}, 32'(bcd_nb), 32'(model_bcd(v)));
        disp_v = v;
        @(negedge clk);
        check({tag, "_done_pulse"}, {30'd0, busy, done}, 32'd0);
    endtask

    task automatic check_display(input string tag);
        logic [3:0] want;
        bit ok;
        for (int d = 0; d < 4; d++) begin
            want = ~(4'b0001 << d);
            ok   = 1'b0;
            for (int i = 0; i < 4 * P + 4 && !ok; i++) begin
                if (an === want) ok = 1'b1;
                else @(negedge clk);
            end
            check($sformatf("%s_an%0d", tag, d), 32'(an), 32'(want));
            check($sformatf("%s_seg%0d", tag, d), 32'(seg), 32'(model_seg(disp_v, d, 1'b1)));
            check($sformatf("%s_segnb%0d", tag, d), 32'(seg_nb),
                  32'(model_seg(disp_v, d, 1'b0)));
        end
    endtask

    initial begin
        int v;
        int done_cnt;
        rst   = 1'b0;
        load  = 1'b0;
        value = '0;
        #12;
        check("rst_an", 32'(an), 32'b1110);
        check("rst_seg", 32'(seg), 32'b1000000);
        check("rst_busy_done", {30'd0, busy, done}, 32'd0);
        check("rst_bcd_ovf", {15'd0, ovf, bcd_out}, 32'd0);

        @(negedge clk);
        rst = 1'b1;
        for (int s = 0; s < 16; s++) begin
            check($sformatf("scan_%0d", s), 32'(an), 32'(4'(~(4'b0001 << ((s / P) % 4)))));
            check($sformatf("scan_nb_%0d", s), 32'(an_nb), 32'(an));
            @(negedge clk);
        end

        convert(1234, "v1234");
        check_display("d1234");
        convert(9999, "v9999");
        check_display("d9999");
        convert(10000, "v10000");
        check_display("d10000");
        convert(65535, "v65535");
        check_display("d65535");
        convert(7, "v7");
        check_display("d7");
        convert(0, "v0");
        check_display("d0");

        // Second load while busy is dropped.
        @(negedge clk);
        value = 16'd42;
        load  = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (3) @(negedge clk);
        value = 16'd99;
        load  = 1'b1;
        @(negedge clk);
        load = 1'b0;
        wait_done("ovl");
        check("ovl_bcd", 32'(bcd_out), 32'h0042);
        disp_v = 42;
        // Load in the done cycle is accepted.
        value = 16'd99;
        load  = 1'b1;
        @(negedge clk);
        load = 1'b0;
        wait_done("dcyc");
        check("dcyc_bcd", 32'(bcd_out), 32'h0099);
        disp_v = 99;
        @(negedge clk);

        // Reset in the middle of a conversion.
        value = 16'd4321;
        load  = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (8) @(negedge clk);
        check("mid_busy_before", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        check("mid_rst_busy_done", {30'd0, busy, done}, 32'd0);
        check("mid_rst_bcd_ovf", {15'd0, ovf, bcd_out}, 32'd0);
        check("mid_rst_an_seg", {21'd0, an, seg}, {21'd0, 4'b1110, 7'b1000000});
        disp_v = 0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 24; i++) begin
            if (done) done_cnt++;
            @(negedge clk);
        end
        check("mid_no_done", 32'(done_cnt), 32'd0);
        check("mid_bcd_zero", 32'(bcd_out), 32'd0);
        convert(5, "v5");
        check_display("d5");

        for (int n = 0; n < 12; n++) begin
            unique case (n % 3)
                0: v = int'($urandom_range(0, 65535));
                1: v = int'($urandom_range(0, 9999));
                default: v = int'($urandom_range(0, 120));
            endcase
            convert(v, $sformatf("rnd%0d", n));
            check_display($sformatf("rd%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
